// File: rtl/uart_rx_palabra.sv
// UART receiver feeding the 8-byte word assembler: 8N1 by default, 8E1 when
// UART_RX_PARITY_EN is defined. Good bytes appear on dato with a one-cycle rx_flat strobe.
module uart_rx_palabra #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned CNT_W        = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] dato,
    output logic       rx_flat,
    output logic       frame_err,
    output logic       parity_err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_idx;
    logic [2:0]       w_idx_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic [7:0]       r_dato;
    logic [7:0]       w_dato_nxt;
    logic             r_flat;
    logic             w_flat_nxt;
    logic             r_ferr;
    logic             w_ferr_nxt;
    logic             r_busy;
    logic             w_rx_s;
    logic             w_expire;
`ifdef UART_RX_PARITY_EN
    logic             r_par_bad;
    logic             w_par_bad_nxt;
    logic             r_perr;
    logic             w_perr_nxt;
`endif

    assign w_rx_s   = r_sync2;
    // Counter sits at 1 on the expiry cycle; <= guards an unreachable zero from sticking.
    assign w_expire = (r_cnt <= CNT_ONE);

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_idx     <= '0;
            r_shift   <= '0;
            r_dato    <= '0;
            r_flat    <= 1'b0;
            r_ferr    <= 1'b0;
            r_busy    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_idx     <= w_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_dato    <= w_dato_nxt;
            r_flat    <= w_flat_nxt;
            r_ferr    <= w_ferr_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
`ifdef UART_RX_PARITY_EN
            r_par_bad <= w_par_bad_nxt;
            r_perr    <= w_perr_nxt;
`endif
        end
    end

    // Next-state and next-output logic; every sample is taken on counter expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_dato_nxt  = r_dato;
        w_flat_nxt  = 1'b0;
        w_ferr_nxt  = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad_nxt = r_par_bad;
        w_perr_nxt    = 1'b0;
`endif
        if (r_state != S_IDLE && !w_expire) begin
            w_cnt_nxt = r_cnt - CNT_ONE;
        end

        case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_cnt_nxt   = CNT_HALF;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_expire) begin
                    if (w_rx_s) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt   = CNT_FULL;
                        w_idx_nxt   = 3'd0;
                        w_state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (w_expire) begin
                    w_shift_nxt = {w_rx_s, r_shift[7:1]};
                    w_cnt_nxt   = CNT_FULL;
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_expire) begin
                    w_par_bad_nxt = w_rx_s ^ (^r_shift);
                    w_cnt_nxt     = CNT_FULL;
                    w_state_nxt   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_expire) begin
                    w_state_nxt = S_IDLE;
                    if (!w_rx_s) begin
                        w_ferr_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
                    end else if (r_par_bad) begin
                        w_perr_nxt = 1'b1;
`endif
                    end else begin
                        w_flat_nxt = 1'b1;
                        w_dato_nxt = r_shift;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign dato      = r_dato;
    assign rx_flat   = r_flat;
    assign frame_err = r_ferr;
    assign busy      = r_busy;
`ifdef UART_RX_PARITY_EN
    assign parity_err = r_perr;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_palabra.sv
// Bench for uart_rx_palabra: a precomputed line waveform is scanned by a
// mid-bit sampling model to give the expected outputs for every cycle.
module tb_uart_rx_palabra;

    localparam int C = 16;
    localparam int H = C / 2;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int P = H + (9 + PB) * C;   // start-edge to stop-sample offset
    localparam int N = 16000;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] dato;
    logic       rx_flat;
    logic       frame_err;
    logic       parity_err;
    logic       busy;

    uart_rx_palabra #(.CLKS_PER_BIT(C), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .rx(rx), .dato(dato), .rx_flat(rx_flat),
        .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
    );

    always #5 clk = ~clk;

    logic        line_arr [N];
    logic        rst_arr  [N];
    logic [11:0] exp_arr  [N];
    bit          ev_ok [N];
    bit          ev_fe [N];
    bit          ev_pe [N];
    bit          bz    [N];
    logic [7:0]  ev_byte [N];

    int  wp;
    int  cur;
    int  dir_end;
    bit  active;
    int  n_vec;
    int  n_err;
    int  ferr_dir;
    int  perr_dir;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic put(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            line_arr[wp] = v;
            rst_arr[wp]  = 1'b1;
            wp++;
        end
    endtask

    // One frame; sc stretches every bit by sc/1000 to emulate baud mismatch.
    task automatic send(input logic [7:0] d, input logic stop, input logic par, input int sc);
        logic bits [12];
        int nb;
        int base;
        int b0;
        int b1;
        nb = 10 + PB;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        bits[9] = par;
        bits[nb-1] = stop;
        base = wp;
        for (int k = 0; k < nb; k++) begin
            b0 = base + (k * C * sc) / 1000;
            b1 = base + ((k + 1) * C * sc) / 1000;
            for (int j = b0; j < b1; j++) begin
                line_arr[j] = bits[k];
                rst_arr[j]  = 1'b1;
            end
        end
        wp = base + (nb * C * sc) / 1000;
    endtask

    // Sampling model: a start seen at line index t is sampled at t+H+k*C,
    // the result is visible two cycles after the deciding sample.
    task automatic run_model();
        int p;
        int t;
        int last;
        int e;
        int r;
        logic glitch;
        logic stop;
        logic pbad;
        logic [7:0] d;
        logic [7:0] cur_d;
        for (int i = 0; i < N; i++) begin
            ev_ok[i] = 0; ev_fe[i] = 0; ev_pe[i] = 0; bz[i] = 0; ev_byte[i] = 8'h00;
        end
        p = 0;
        while (p < wp) begin
            if (rst_arr[p] == 1'b0 || line_arr[p] == 1'b1) begin
                p++;
                continue;
            end
            t = p;
            glitch = line_arr[t+H];
            last = glitch ? t + H : t + P;
            e = last + 2;
            if (e >= N) break;
            r = -1;
            for (int i = t; i <= e; i++) begin
                if (rst_arr[i] == 1'b0) begin
                    r = i;
                    break;
                end
            end
            for (int i = t + 2; i < e; i++) begin
                if (r >= 0 && i >= r) break;
                bz[i] = 1;
            end
            if (r >= 0) begin
                p = r;
                continue;
            end
            if (!glitch) begin
                for (int b = 0; b < 8; b++) d[b] = line_arr[t+H+(b+1)*C];
                stop = line_arr[t+P];
                pbad = (PB == 1) && (line_arr[t+H+9*C] != (^d));
                if (!stop)     ev_fe[e] = 1;
                else if (pbad) ev_pe[e] = 1;
                else begin
                    ev_ok[e] = 1;
                    ev_byte[e] = d;
                end
            end
            p = last + 1;
        end
        cur_d = 8'h00;
        for (int n = 0; n < N; n++) begin
            if (rst_arr[n] == 1'b0) begin
                cur_d = 8'h00;
                exp_arr[n] = 12'h000;
            end else begin
                if (ev_ok[n]) cur_d = ev_byte[n];
                exp_arr[n] = {bz[n], ev_pe[n], ev_fe[n], ev_ok[n], cur_d};
            end
        end
    endtask

    // Per-cycle comparison against the model, plus directed-phase capture.
    always @(posedge clk) begin
        #1;
        if (active) begin
            chk($sformatf("cyc%0d busy/perr/ferr/flat/dato", cur),
                64'({busy, parity_err, frame_err, rx_flat, dato}), 64'(exp_arr[cur]));
            if (cur < dir_end) begin
                if (rx_flat)    got_q.push_back(dato);
                if (frame_err)  ferr_dir++;
                if (parity_err) perr_dir++;
            end
        end
    end

    initial begin
        int t0;
        int kind;
        logic [7:0] d;
        logic [63:0] word;
        rst = 1'b0;
        rx  = 1'b1;
        active = 1'b0;
        for (int i = 0; i < N; i++) begin
            line_arr[i] = 1'b1;
            rst_arr[i]  = 1'b1;
        end
        wp = 0;
        put(1'b1, 20);
        for (int i = 0; i < 4; i++) rst_arr[i] = 1'b0;

        send(8'hA5, 1'b1, 1'b0, 1000);                 put(1'b1, 10);
        exp_q.push_back(8'hA5);
        put(1'b0, 4);                                   put(1'b1, 30);
        send(8'h3C, 1'b0, 1'b0, 1000);                 put(1'b1, 20);
        for (int i = 1; i <= 8; i++) begin
            send(8'(i), 1'b1, ^(8'(i)), 1000);
            exp_q.push_back(8'(i));
        end
        put(1'b1, 20);
        t0 = wp;
        send(8'hFF, 1'b1, 1'b0, 1000);                 put(1'b1, 20);
        for (int i = 0; i < 3; i++) rst_arr[t0 + 5*C + 4 + i] = 1'b0;
        send(8'h5A, 1'b1, 1'b0, 1000);                 put(1'b1, 20);
        exp_q.push_back(8'h5A);
        if (PB == 1) begin
            send(8'h0F, 1'b1, 1'b0, 1000);             put(1'b1, 10);
            send(8'h0F, 1'b1, 1'b1, 1000);             put(1'b1, 10);
            exp_q.push_back(8'h0F);
        end
        put(1'b0, 4*P + 4);                             put(1'b1, 40);
        dir_end = wp;

        while (wp < N - 600) begin
            kind = int'($urandom % 10);
            if (kind == 0) begin
                put(1'b0, 1 + int'($urandom % (H - 2)));
                put(1'b1, 20);
            end else begin
                d = 8'($urandom);
                send(d, ($urandom % 8) != 0, (^d) ^ (($urandom % 6) == 0),
                     970 + int'($urandom % 61));
                put(1'b1, int'($urandom % 25));
            end
        end
        put(1'b1, 200);

        run_model();

        active = 1'b1;
        for (int n = 0; n < wp; n++) begin
            @(negedge clk);
            rx  = line_arr[n];
            rst = rst_arr[n];
            cur = n;
        end
        @(negedge clk);
        active = 1'b0;

        chk("directed byte count", 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("directed byte %0d", i),
                (i < got_q.size()) ? 64'(got_q[i]) : 64'h1FF, 64'(exp_q[i]));
        chk("directed frame_err pulses", 64'(ferr_dir), 64'd5);
        chk("directed parity_err pulses", 64'(perr_dir), 64'(PB));
        word = 64'h0;
        for (int i = 1; i <= 8; i++)
            if (i < got_q.size()) word[8*(i-1) +: 8] = got_q[i];
        chk("assembled word", word, 64'h0807060504030201);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_palabra.md
# uart_rx_palabra

Serial receiver directly upstream of the 8-byte word assembler. It deserialises an asynchronous 8N1 UART line (optionally 8E1) into bytes and presents each good byte on `dato` with a one-cycle `rx_flat` strobe. These outputs are exactly the byte/strobe pair the assembler consumes. Framing and parity errors are flagged, and the affected byte is never delivered downstream.

## Interface
- `CLKS_PER_BIT`, default 434: clock cycles per bit; 434 gives 50 MHz / 115200 baud. Must be ≥ 8.
- `CNT_W`, default 9: counter width; must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `dato`  out  8  last good received byte.
- `rx_flat`  out  1  one-cycle strobe marking a new valid `dato`.
- `frame_err`  out  1  one-cycle strobe when a stop bit is sampled low.
- `parity_err`  out  1  one-cycle strobe on parity mismatch (see Configuration).
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Input synchronisation:** `rx` passes through a 2-FF synchroniser. Both flops reset to 1. All decisions use the synchronised value `rx_s`.
- **IDLE:** wait for `rx_s` == 0. Load the bit counter with CLKS_PER_BIT/2 (integer division), then go to START.
- **START:** when the counter expires, sample `rx_s`.
  - If 1: treat as a false start (glitch) and return to IDLE with no strobe.
  - If 0: reload the counter with CLKS_PER_BIT, clear the bit index, go to DATA.
- **DATA:** sample `rx_s` at each counter expiry, i.e. at the middle of each bit.
  - Shift the sample into the shift register, LSB first.
  - After 8 samples go to PARITY if it is compiled in, otherwise to STOP.
- **PARITY:** sample once. Record a mismatch if the sample ≠ XOR of the 8 data bits (even parity). Go to STOP.
- **STOP:** sample once, then return to IDLE in the next cycle. There is no wait for the end of the stop bit, so back-to-back frames are accepted.
  - Stop = 1 and no parity mismatch: `dato` ← shift register; pulse `rx_flat`.
  - Stop = 0: pulse `frame_err`. Do not pulse `rx_flat`. `dato` is unchanged.
  - Stop = 1 with a parity mismatch: pulse `parity_err`. Do not pulse `rx_flat`. `dato` is unchanged.
  - `frame_err` takes priority: if both errors occur, only `frame_err` pulses.
- **Strobe rules:** `rx_flat`, `frame_err` and `parity_err` are never high for two consecutive cycles, and never high together.
- **Counter:** it is a down-counter; "expiry" means the counter equals 1, at which point it reloads. Arithmetic uses CNT_W bits and never wraps below 0.
- **Line held low:** if `rx` stays low (break condition), every frame reads 0x00 with a low stop bit. The result is repeated `frame_err` pulses, one per frame length; no `rx_flat`.

## Timing
- **Reset values:** `dato` = 0x00; `rx_flat`, `frame_err`, `parity_err`, `busy` = 0; FSM = IDLE; synchroniser = 1.
- **Reset mid-frame:** the partial byte is discarded, all outputs go to their reset values immediately, and no strobe occurs after reset is released.
- **Start-edge latency:** the falling edge on `rx` reaches `rx_s` after 2 cycles.
- **Output latency:** `rx_flat` rises on the cycle after the stop-bit mid-sample. That is roughly 9.5 bit times (10.5 with parity) after the start edge, plus 2–3 cycles.
- **`dato` update:** `dato` changes in the same cycle that `rx_flat` rises and holds until the next good byte.
- **Throughput:** one byte per 10 bit times (11 with parity).
- **Downstream handshake:** none. The downstream stage must accept the byte in the strobe cycle.
- **Baud tolerance:** ±3 % baud mismatch must be received correctly.

## Configuration
- **Macro:** `UART_RX_PARITY_EN`.
- **Defined:** the frame is 8E1; the PARITY state is present and `parity_err` is active as described above.
- **Undefined:** the frame is 8N1; the PARITY state is absent and `parity_err` is tied to 0.

## Test plan
All scenarios use CLKS_PER_BIT = 16 and macro undefined unless stated.
- **Single byte:** send 0xA5 as 8N1 → exactly one `rx_flat` pulse; `dato` = 0xA5; `frame_err` stays 0.
- **Glitch:** drive `rx` low for 4 cycles, then high → no strobe of any kind; `busy` returns to 0 within 8 cycles.
- **Framing error:** send 0x3C with stop bit = 0 → one `frame_err` pulse, no `rx_flat`; `dato` keeps its previous value 0xA5.
- **Back-to-back into the assembler:** send 0x01…0x08 with no idle gap → 8 `rx_flat` pulses with `dato` = 0x01…0x08 in order; the downstream assembler outputs 0x0807060504030201.
- **Reset mid-frame:** assert `rst` during bit 4 of 0xFF, release it, then send 0x5A → only one `rx_flat`, with `dato` = 0x5A.
- **Parity (macro defined):** send 0x0F with parity bit 0 → `rx_flat`, `dato` = 0x0F. Then send 0x0F with parity bit 1 → `parity_err` pulse only; `dato` stays 0x0F.
